video_fetch_ctrl: RTL

- Sequences the video fetch datapath for one scanline.
- Issues 16-bit DRAM read requests and tracks the order in which read data returns.
- Drives the per-strobe byte-lane controls (f_sel/b_sel) that assemble each 32-bit fetch unit.
- Pulses fetch_stb to transfer a completed unit into the one-deep pixel slot, then paces further fetches against pixel-pipe consumption.

---
 rtl/video_fetch_ctrl.sv | 294 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/video_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// video_fetch_ctrl
//
// Sequences the DRAM read traffic for one video scanline. A line is a run of
// 32-bit fetch units. Each unit takes two 16-bit word reads. The controller:
//   * issues the two read requests of a unit and holds each one until accepted,
//   * keeps a 2-entry tag FIFO so it knows which byte lanes each returning
//     strobe fills (read data returns strictly in request order),
//   * pulses fetch_stb once both halves of a unit have landed, which copies the
//     unit into the one-deep pixel slot,
//   * holds back the next unit until the pixel pipe has freed (or is freeing)
//     that slot.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   line_start          latch mode/bases/units and (re)start a line
//   mode                0 = ZX (pixel byte + attribute byte), 1 = linear words
//   pix_base            ZX pixel byte address / linear word address (low AW bits)
//   attr_base           ZX attribute byte address
//   units               number of 32-bit units in the line (0 = empty line)
//   video_req/addr      DRAM read request and word address
//   video_next          request accepted this cycle
//   video_strobe        read data valid (in request order)
//   f_sel, b_sel        byte-lane enables / byte selects for the current strobe
//   fetch_stb           transfer the assembled unit into the pixel slot
//   slot_full           pixel slot holds an unconsumed unit
//   pix_take            pixel pipe consumed the slot
//   line_done           one-cycle pulse when the last unit is delivered
// -----------------------------------------------------------------------------
module video_fetch_ctrl #(
  parameter int AW = 21,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          line_start,
  input  logic          mode,
  input  logic [AW:0]   pix_base,
  input  logic [AW:0]   attr_base,
  input  logic [CW-1:0] units,
  output logic          video_req,
  output logic [AW-1:0] video_addr,
  input  logic          video_next,
  input  logic          video_strobe,
  output logic [3:0]    f_sel,
  output logic [1:0]    b_sel,
  output logic          fetch_stb,
  output logic          slot_full,
  input  logic          pix_take,
  output logic          line_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // One tag per accepted request: which lanes the returning word fills and
  // whether it completes the unit.
  typedef struct packed {
    logic       last;
    logic [1:0] b;
    logic [3:0] f;
  } tag_t;

  localparam logic [AW:0]   PTR_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   PTR_TWO  = (AW+1)'(2);
  localparam logic [AW-1:0] WORD_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_reg, state_next;

  logic          mode_reg;
  logic [AW:0]   pix_ptr_reg;
  logic [AW:0]   attr_ptr_reg;
  logic [CW-1:0] remaining_reg;
  logic          req_idx_reg;     // 0 = first word of the unit, 1 = second
  logic          flush_reg;       // discard completions from an abandoned line
  logic          slot_full_reg;
  logic          fetch_stb_reg;
  logic          line_done_reg;

  tag_t          tag_mem_reg [2];
  logic          wr_ptr_reg;
  logic          rd_ptr_reg;
  logic [1:0]    count_reg;
  logic [1:0]    count_next;

  tag_t          head_tag;
  tag_t          push_tag;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic          unit_done;
  logic          start_ok;

  assign fifo_empty = (count_reg == 2'd0);
  assign head_tag   = tag_mem_reg[rd_ptr_reg];
  assign pop        = video_strobe && !fifo_empty;
  assign push       = video_req && video_next;

  // A unit completes when its last tag pops, unless it belongs to a line that
  // was abandoned (flush) or is being abandoned right now (line_start).
  assign unit_done  = pop && head_tag.last && !flush_reg && !line_start;

  // A new unit may begin only with nothing in flight, no transfer into the
  // slot already scheduled, and the slot free or being freed this cycle.
  assign start_ok   = (state_reg == ST_WAIT) && !line_start &&
                      (remaining_reg != '0) && fifo_empty && !flush_reg &&
                      !fetch_stb_reg && (!slot_full_reg || pix_take);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    if (line_start) begin
      state_next = (units == '0) ? ST_IDLE : ST_WAIT;
    end else begin
      case (state_reg)
        ST_IDLE: state_next = ST_IDLE;
        ST_WAIT: begin
          if (unit_done && (remaining_reg == CNT_ONE)) begin
            state_next = ST_IDLE;
          end else if (start_ok) begin
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (push && req_idx_reg) begin
            state_next = ST_WAIT;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    video_req  = 1'b0;
    video_addr = '0;
    push_tag   = '0;
    f_sel      = 4'b0000;
    b_sel      = 2'b00;

    // The first request of a unit is presented in the same cycle the slot
    // frees up; after that ISSUE holds it. line_start withdraws it at once.
    if (!line_start && ((state_reg == ST_ISSUE) || start_ok)) begin
      video_req = 1'b1;
    end

    if (video_req) begin
      if (mode_reg) begin
        if (!req_idx_reg) begin
          video_addr = pix_ptr_reg[AW-1:0];
          push_tag   = '{last: 1'b0, b: 2'b10, f: 4'b0011};
        end else begin
          video_addr = pix_ptr_reg[AW-1:0] + WORD_ONE;
          push_tag   = '{last: 1'b1, b: 2'b00, f: 4'b1100};
        end
      end else begin
        // ZX pointers are byte addresses: the low bit selects the byte.
        if (!req_idx_reg) begin
          video_addr = pix_ptr_reg[AW:1];
          push_tag   = '{last: 1'b0, b: {1'b0, pix_ptr_reg[0]}, f: 4'b0001};
        end else begin
          video_addr = attr_ptr_reg[AW:1];
          push_tag   = '{last: 1'b1, b: {attr_ptr_reg[0], 1'b0}, f: 4'b0010};
        end
      end
    end

    if (pop) begin
      f_sel = head_tag.f;
      b_sel = head_tag.b;
    end
  end

  assign fetch_stb = fetch_stb_reg;
  assign slot_full = slot_full_reg;
  assign line_done = line_done_reg;

  // ---------------------------------------------------------------------------
  // Tag FIFO occupancy
  // ---------------------------------------------------------------------------
  always_comb begin
    case ({push, pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        tag_mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (push) begin
        tag_mem_reg[wr_ptr_reg] <= push_tag;
        wr_ptr_reg              <= ~wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      count_reg <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Line configuration, pointers and unit pacing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_reg      <= 1'b0;
      pix_ptr_reg   <= '0;
      attr_ptr_reg  <= '0;
      remaining_reg <= '0;
      req_idx_reg   <= 1'b0;
      flush_reg     <= 1'b0;
      slot_full_reg <= 1'b0;
      fetch_stb_reg <= 1'b0;
      line_done_reg <= 1'b0;
    end else begin
      if (line_start) begin
        mode_reg      <= mode;
        pix_ptr_reg   <= pix_base;
        attr_ptr_reg  <= attr_base;
        remaining_reg <= units;
      end else begin
        // Pointers advance once the unit's second request has been accepted.
        if (push && req_idx_reg) begin
          if (mode_reg) begin
            pix_ptr_reg <= pix_ptr_reg + PTR_TWO;
          end else begin
            pix_ptr_reg  <= pix_ptr_reg + PTR_ONE;
            attr_ptr_reg <= attr_ptr_reg + PTR_ONE;
          end
        end
        if (unit_done) begin
          remaining_reg <= remaining_reg - CNT_ONE;
        end
      end

      if (line_start) begin
        req_idx_reg <= 1'b0;
      end else if (push) begin
        req_idx_reg <= ~req_idx_reg;
      end

      // Tags still in the FIFO at line_start belong to the old line; keep
      // discarding their completions until the FIFO has drained.
      if (line_start) begin
        flush_reg <= (count_next != 2'd0);
      end else if (count_next == 2'd0) begin
        flush_reg <= 1'b0;
      end

      fetch_stb_reg <= unit_done;
      line_done_reg <= (unit_done && (remaining_reg == CNT_ONE)) ||
                       (line_start && (units == '0));

      // The slot fills with the fetch_stb transfer; a take in that same
      // cycle consumed the previous contents, so the slot stays full.
      if (line_start) begin
        slot_full_reg <= 1'b0;
      end else if (fetch_stb_reg) begin
        slot_full_reg <= 1'b1;
      end else if (pix_take) begin
        slot_full_reg <= 1'b0;
      end
    end
  end

endmodule
